// File: rtl/conv1d_par_relu.sv
// Run-time-loaded 1-D convolution: P MAC lanes share f[k], each lane walks its own x window.
// Three-stage MAC pipeline (operand fetch, saturated product, saturated accumulate); y held stable while stalled.
module conv1d_par_relu #(
  parameter int N    = 128,
  parameter int M    = 8,
  parameter int T    = 16,
  parameter int P    = 2,
  parameter int RELU = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [T-1:0] x_data,
  input  logic         x_valid,
  output logic         x_ready,
  input  logic [T-1:0] f_data,
  input  logic         f_valid,
  output logic         f_ready,
  output logic [T-1:0] y_data,
  output logic         y_valid,
  input  logic         y_ready
);

  localparam int L   = N - M + 1;
  localparam int CW  = $clog2(N + 1);
  localparam int XAW = (N > 1) ? $clog2(N) : 1;
  localparam int FW  = $clog2(M + 1);
  localparam int FAW = (M > 1) ? $clog2(M) : 1;
  localparam int KW  = $clog2(M + 2);
  localparam int JW  = (P > 1) ? $clog2(P) : 1;

  localparam logic [T-1:0] SMAX = {1'b0, {(T-1){1'b1}}};
  localparam logic [T-1:0] SMIN = {1'b1, {(T-1){1'b0}}};

  typedef enum logic [2:0] {
    S_INIT,
    S_LOAD,
    S_CLEAR,
    S_COMPUTE,
    S_OUT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] x_cnt_q, x_cnt_d;
  logic [FW-1:0] f_cnt_q, f_cnt_d;
  logic [CW-1:0] base_q, base_d;
  logic [KW-1:0] cc_q, cc_d;
  logic [JW-1:0] j_q, j_d;
  logic [T-1:0]  acc_q [P];
  logic [T-1:0]  acc_d [P];
  logic [T-1:0]  y_data_q, y_data_d;
  logic          y_valid_q, y_valid_d;
  logic          x_ready_q, x_ready_d;
  logic          f_ready_q, f_ready_d;

  logic [T-1:0]  x_mem [N];
  logic [T-1:0]  f_mem [M];

  logic [T-1:0]  s1_x_q [P];
  logic [T-1:0]  s1_f_q;
  logic          s1_vld_q;
  logic [T-1:0]  s2_p_q [P];
  logic          s2_vld_q;

  logic [T-1:0]  x_rd [P];
  logic [T-1:0]  f_rd;
  logic          issue;
  logic          x_fire;
  logic          f_fire;

  function automatic logic [T-1:0] sat_mul(input logic [T-1:0] a, input logic [T-1:0] b);
    logic signed [2*T-1:0] prod;
    prod = $signed({{T{a[T-1]}}, a}) * $signed({{T{b[T-1]}}, b});
    // the product fits in T bits only when its top T+1 bits are a pure sign run
    if ((prod[2*T-1:T-1] == '0) || (prod[2*T-1:T-1] == '1)) begin
      return prod[T-1:0];
    end
    return prod[2*T-1] ? SMIN : SMAX;
  endfunction

  function automatic logic [T-1:0] sat_add(input logic [T-1:0] a, input logic [T-1:0] b);
    logic [T:0] sum;
    sum = {a[T-1], a} + {b[T-1], b};
    if (sum[T] != sum[T-1]) begin
      return sum[T] ? SMIN : SMAX;
    end
    return sum[T-1:0];
  endfunction

  function automatic logic [T-1:0] relu_f(input logic [T-1:0] v);
    if ((RELU != 0) && v[T-1]) begin
      return '0;
    end
    return v;
  endfunction

  assign x_fire = x_valid && x_ready_q;
  assign f_fire = f_valid && f_ready_q;
  assign issue  = (state_q == S_COMPUTE) && (cc_q < KW'(M));

  always_comb begin
    f_rd = '0;
    for (int p = 0; p < P; p++) begin
      x_rd[p] = '0;
    end
    if (issue) begin
      f_rd = f_mem[FAW'(int'(cc_q))];
      for (int p = 0; p < P; p++) begin
        x_rd[p] = x_mem[XAW'(int'(base_q) + p + int'(cc_q))];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    x_cnt_d  = x_cnt_q;
    f_cnt_d  = f_cnt_q;
    base_d   = base_q;
    cc_d     = cc_q;
    j_d      = j_q;
    y_data_d = y_data_q;
    for (int p = 0; p < P; p++) begin
      acc_d[p] = acc_q[p];
    end

    case (state_q)
      S_INIT: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        if (x_fire) x_cnt_d = x_cnt_q + 1'b1;
        if (f_fire) f_cnt_d = f_cnt_q + 1'b1;
        if ((x_cnt_d == CW'(N)) && (f_cnt_d == FW'(M))) begin
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        for (int p = 0; p < P; p++) begin
          acc_d[p] = '0;
        end
        cc_d    = '0;
        state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
        cc_d = cc_q + 1'b1;
        if (s2_vld_q) begin
          for (int p = 0; p < P; p++) begin
            acc_d[p] = sat_add(acc_q[p], s2_p_q[p]);
          end
        end
        // the final product lands in the accumulators on this same edge
        if (cc_q == KW'(M + 1)) begin
          state_d  = S_OUT;
          j_d      = '0;
          y_data_d = relu_f(acc_d[0]);
        end
      end
      S_OUT: begin
        if (y_valid_q && y_ready) begin
          if (j_q == JW'(P - 1)) begin
            if (base_q + CW'(P) == CW'(L)) begin
              state_d = S_LOAD;
              x_cnt_d = '0;
              f_cnt_d = '0;
              base_d  = '0;
            end else begin
              base_d  = base_q + CW'(P);
              state_d = S_CLEAR;
            end
          end else begin
            j_d      = j_q + 1'b1;
            y_data_d = relu_f(acc_q[j_q + 1'b1]);
          end
        end
      end
      default: begin
        state_d = S_INIT;
      end
    endcase

    x_ready_d = (state_d == S_LOAD) && (x_cnt_d < CW'(N));
    f_ready_d = (state_d == S_LOAD) && (f_cnt_d < FW'(M));
    y_valid_d = (state_d == S_OUT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_INIT;
      x_cnt_q   <= '0;
      f_cnt_q   <= '0;
      base_q    <= '0;
      cc_q      <= '0;
      j_q       <= '0;
      y_data_q  <= '0;
      y_valid_q <= 1'b0;
      x_ready_q <= 1'b0;
      f_ready_q <= 1'b0;
      s1_f_q    <= '0;
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      for (int p = 0; p < P; p++) begin
        acc_q[p]  <= '0;
        s1_x_q[p] <= '0;
        s2_p_q[p] <= '0;
      end
      for (int i = 0; i < N; i++) begin
        x_mem[i] <= '0;
      end
      for (int i = 0; i < M; i++) begin
        f_mem[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      x_cnt_q   <= x_cnt_d;
      f_cnt_q   <= f_cnt_d;
      base_q    <= base_d;
      cc_q      <= cc_d;
      j_q       <= j_d;
      y_data_q  <= y_data_d;
      y_valid_q <= y_valid_d;
      x_ready_q <= x_ready_d;
      f_ready_q <= f_ready_d;
      if (x_fire) x_mem[x_cnt_q[XAW-1:0]] <= x_data;
      if (f_fire) f_mem[f_cnt_q[FAW-1:0]] <= f_data;
      s1_vld_q <= issue;
      s2_vld_q <= s1_vld_q;
      if (issue) s1_f_q <= f_rd;
      for (int p = 0; p < P; p++) begin
        acc_q[p]  <= acc_d[p];
        s2_p_q[p] <= sat_mul(s1_x_q[p], s1_f_q);
        if (issue) s1_x_q[p] <= x_rd[p];
      end
    end
  end

  assign x_ready = x_ready_q;
  assign f_ready = f_ready_q;
  assign y_data  = y_data_q;
  assign y_valid = y_valid_q;

endmodule

// File: tb/tb_conv1d_par_relu.sv
// Scoreboard bench: two engines (ReLU on / off) share one stimulus stream; a negedge monitor pops expectations.
module tb_conv1d_par_relu;
  localparam int N = 17;
  localparam int M = 4;
  localparam int T = 16;
  localparam int P = 2;
  localparam int L = N - M + 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [T-1:0] x_data, f_data;
  logic         x_valid, f_valid, y_ready;
  logic         xa_ready, fa_ready, ya_valid;
  logic [T-1:0] ya_data;
  logic         xb_ready, fb_ready, yb_valid;
  logic [T-1:0] yb_data;

  conv1d_par_relu #(.N(N), .M(M), .T(T), .P(P), .RELU(1)) u_relu (
    .clk(clk), .reset(reset),
    .x_data(x_data), .x_valid(x_valid), .x_ready(xa_ready),
    .f_data(f_data), .f_valid(f_valid), .f_ready(fa_ready),
    .y_data(ya_data), .y_valid(ya_valid), .y_ready(y_ready)
  );

  conv1d_par_relu #(.N(N), .M(M), .T(T), .P(P), .RELU(0)) u_lin (
    .clk(clk), .reset(reset),
    .x_data(x_data), .x_valid(x_valid), .x_ready(xb_ready),
    .f_data(f_data), .f_valid(f_valid), .f_ready(fb_ready),
    .y_data(yb_data), .y_valid(yb_valid), .y_ready(y_ready)
  );

  typedef struct packed {
    logic [T-1:0] a;
    logic [T-1:0] b;
  } exp_t;

  exp_t         q[$];
  int           hs[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  bit           stall_mode = 1'b0;
  bit           prev_stall = 1'b0;
  logic [T-1:0] prev_data;
  logic [T-1:0] xv[N];
  logic [T-1:0] fv[M];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  initial begin
    y_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      y_ready = stall_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_hold", ya_valid, 1);
        chk("stall_data_hold", ya_data, prev_data);
      end
      if (ya_valid && y_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_y", ya_data, 32'hDEAD);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("y_relu", ya_data, e.a);
          chk("y_lin_valid", yb_valid, 1);
          chk("y_lin", yb_data, e.b);
          hs.push_back(cyc);
        end
      end
      prev_stall = ya_valid && !y_ready;
      prev_data  = ya_data;
    end
  end

  // kind: 0 identity, 1 sliding sum, 2 positive saturation, 3 negative saturation, 4 negate
  task automatic set_job(input int kind, input bit push);
    logic [T-1:0] lin;
    exp_t e;
    for (int n = 0; n < N; n++) begin
      xv[n] = (kind == 2 || kind == 3) ? 16'h7FFF : 16'(n + 1);
    end
    for (int k = 0; k < M; k++) begin
      case (kind)
        0:       fv[k] = (k == 0) ? 16'h0001 : 16'h0000;
        1:       fv[k] = 16'h0001;
        2:       fv[k] = 16'h7FFF;
        3:       fv[k] = 16'h8000;
        default: fv[k] = (k == 0) ? 16'hFFFF : 16'h0000;
      endcase
    end
    if (push) begin
      hs.delete();
      for (int n = 0; n < L; n++) begin
        case (kind)
          0:       lin = 16'(n + 1);
          1:       lin = 16'(4 * n + 10);
          2:       lin = 16'h7FFF;
          3:       lin = 16'h8000;
          default: lin = 16'(-(n + 1));
        endcase
        e.a = lin[T-1] ? 16'h0000 : lin;
        e.b = lin;
        q.push_back(e);
      end
    end
  endtask

  task automatic run_load(input int x_start, input int f_start, input bit check_lat);
    int xi = 0;
    int fi = 0;
    int c = 0;
    int d = 0;
    bit xa, fa;
    while ((xi < N || fi < M) && c < 500) begin
      @(negedge clk);
      x_valid = (c >= x_start) && (xi < N);
      f_valid = (c >= f_start) && (fi < M);
      if (xi < N) x_data = xv[xi];
      if (fi < M) f_data = fv[fi];
      xa = x_valid && xa_ready;
      fa = f_valid && fa_ready;
      @(posedge clk);
      if (xa) xi++;
      if (fa) fi++;
      c++;
    end
    chk("load_done", (c < 500), 1);
    #1;
    x_valid = 1'b0;
    f_valid = 1'b0;
    chk("ready_low_in_clear", {xa_ready, fa_ready}, 0);
    if (check_lat) begin
      do begin
        @(posedge clk);
        d++;
        #1;
      end while (!ya_valid && d < 50);
      chk("first_y_latency", d, M + 3);
    end
  endtask

  task automatic wait_drain();
    int c = 0;
    while (q.size() != 0 && c < 3000) begin
      @(posedge clk);
      c++;
    end
    chk("drain_done", (c < 3000), 1);
    #1;
    chk("x_ready_after_job", xa_ready, 1);
    chk("y_valid_after_job", ya_valid, 0);
  endtask

  initial begin
    x_valid = 1'b0;
    f_valid = 1'b0;
    x_data  = '0;
    f_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_x_ready", xa_ready, 0);
    chk("rst_f_ready", fa_ready, 0);
    chk("rst_y_valid", ya_valid, 0);
    chk("rst_y_data", ya_data, 0);
    chk("rst_lin_y_valid", yb_valid, 0);
    @(negedge clk);
    reset = 1'b0;

    // filter fully loaded before the first x
    set_job(0, 1);
    run_load(6, 0, 1);
    wait_drain();
    chk("identity_handshakes", hs.size(), L);

    // x fully loaded before the first f; group spacing with y_ready high
    set_job(1, 1);
    run_load(0, 20, 1);
    wait_drain();
    chk("group_spacing", hs[2] - hs[0], M + P + 3);

    // last x and last f accepted in the same cycle
    set_job(2, 1);
    run_load(0, 13, 1);
    wait_drain();

    set_job(3, 1);
    run_load(0, 0, 1);
    wait_drain();

    set_job(4, 1);
    run_load(0, 0, 1);
    wait_drain();

    // abort a job during COMPUTE
    set_job(0, 0);
    run_load(0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_y_valid", ya_valid, 0);
    chk("midrst_y_data", ya_data, 0);
    chk("midrst_lin_y_data", yb_data, 0);
    chk("midrst_readies", {xa_ready, fa_ready, xb_ready, fb_ready}, 0);
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // fresh job with random output stalls
    stall_mode = 1'b1;
    set_job(1, 1);
    run_load(3, 0, 1);
    wait_drain();
    stall_mode = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
